// File: rtl/rv32_exec_core.sv
// RV32I execute slice: combinational decoder, 32x32 register file with x0 hardwired
// to zero, registered operand read and a registered ALU, sequenced externally.
module rv32_exec_core (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] insn,
    input  logic        rden,
    input  logic        wren,
    input  logic [31:0] wb_link,
    output logic [4:0]  opcode,
    output logic [3:0]  alu_op,
    output logic        invalid,
    output logic [4:0]  rd,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [31:0] imm,
    output logic [31:0] reg1,
    output logic [31:0] reg2,
    output logic [31:0] alu_out
);
    localparam logic [4:0] OPC_LUI    = 5'b01101;
    localparam logic [4:0] OPC_AUIPC  = 5'b00101;
    localparam logic [4:0] OPC_JAL    = 5'b11011;
    localparam logic [4:0] OPC_JALR   = 5'b11001;
    localparam logic [4:0] OPC_BRANCH = 5'b11000;
    localparam logic [4:0] OPC_LOAD   = 5'b00000;
    localparam logic [4:0] OPC_STORE  = 5'b01000;
    localparam logic [4:0] OPC_OPIMM  = 5'b00100;
    localparam logic [4:0] OPC_OP     = 5'b01100;

    logic [2:0]  w_funct3;
    logic [6:0]  w_funct7;
    logic        w_invalid;
    logic [31:0] w_imm;
    logic [3:0]  w_alu_op;
    logic [31:0] w_in2;
    logic [4:0]  w_shamt;
    logic [31:0] w_alu_res;
    logic [31:0] w_wb_data;
    logic        w_we;
    logic [31:0] w_rdata1;
    logic [31:0] w_rdata2;

    logic [31:0] r_xreg [1:31];
    logic [31:0] r_reg1;
    logic [31:0] r_reg2;
    logic [31:0] r_alu_out;

    assign opcode   = insn[6:2];
    assign rd       = insn[11:7];
    assign rs1      = insn[19:15];
    assign rs2      = insn[24:20];
    assign w_funct3 = insn[14:12];
    assign w_funct7 = insn[31:25];

    always_comb begin
        w_invalid = 1'b0;
        case (opcode)
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR,
            OPC_BRANCH, OPC_LOAD, OPC_STORE: w_invalid = 1'b0;
            OPC_OP: begin
                if (w_funct7 == 7'b0100000)
                    w_invalid = !(w_funct3 == 3'b000 || w_funct3 == 3'b101);
                else
                    w_invalid = (w_funct7 != 7'b0000000);
            end
            OPC_OPIMM: begin
                if (w_funct3 == 3'b001)
                    w_invalid = (w_funct7 != 7'b0000000);
                else if (w_funct3 == 3'b101)
                    w_invalid = (w_funct7 != 7'b0000000) && (w_funct7 != 7'b0100000);
                else
                    w_invalid = 1'b0;
            end
            default: w_invalid = 1'b1;
        endcase
        if (insn[1:0] != 2'b11)
            w_invalid = 1'b1;
    end

    // Immediate and ALU op are forced to 0/ADD on illegal words so a stray write-back is benign.
    always_comb begin
        w_imm    = '0;
        w_alu_op = 4'b0000;
        if (!w_invalid) begin
            case (opcode)
                OPC_JALR, OPC_LOAD, OPC_OPIMM:
                    w_imm = {{20{insn[31]}}, insn[31:20]};
                OPC_STORE:
                    w_imm = {{20{insn[31]}}, insn[31:25], insn[11:7]};
                OPC_BRANCH:
                    w_imm = {{19{insn[31]}}, insn[31], insn[7], insn[30:25], insn[11:8], 1'b0};
                OPC_LUI, OPC_AUIPC:
                    w_imm = {insn[31:12], 12'b0};
                OPC_JAL:
                    w_imm = {{11{insn[31]}}, insn[31], insn[19:12], insn[20], insn[30:21], 1'b0};
                default:
                    w_imm = '0;
            endcase
            if (opcode == OPC_OP)
                w_alu_op = {insn[30], w_funct3};
            else if (opcode == OPC_OPIMM)
                w_alu_op = {(w_funct3 == 3'b101) ? insn[30] : 1'b0, w_funct3};
        end
    end

    assign invalid = w_invalid;
    assign imm     = w_imm;
    assign alu_op  = w_alu_op;

    assign w_in2   = (opcode == OPC_OPIMM) ? w_imm : r_reg2;
    assign w_shamt = w_in2[4:0];

    always_comb begin
        case (w_alu_op)
            4'b1000: w_alu_res = r_reg1 - w_in2;
            4'b0001: w_alu_res = r_reg1 << w_shamt;
            4'b0010: w_alu_res = {31'b0, $signed(r_reg1) < $signed(w_in2)};
            4'b0011: w_alu_res = {31'b0, r_reg1 < w_in2};
            4'b0100: w_alu_res = r_reg1 ^ w_in2;
            4'b0101: w_alu_res = r_reg1 >> w_shamt;
            4'b1101: w_alu_res = $unsigned($signed(r_reg1) >>> w_shamt);
            4'b0110: w_alu_res = r_reg1 | w_in2;
            4'b0111: w_alu_res = r_reg1 & w_in2;
            default: w_alu_res = r_reg1 + w_in2;
        endcase
    end

    assign w_wb_data = (opcode == OPC_JAL || opcode == OPC_JALR) ? wb_link : r_alu_out;
    assign w_we      = wren && (rd != 5'd0);

    always_comb begin
        w_rdata1 = '0;
        w_rdata2 = '0;
        for (int i = 1; i < 32; i++) begin
            if (rs1 == 5'(i)) w_rdata1 = r_xreg[i];
            if (rs2 == 5'(i)) w_rdata2 = r_xreg[i];
        end
    end

    // x0 has no storage; the read mux above returns zero for it.
    for (genvar gi = 1; gi < 32; gi++) begin : g_xreg
        always_ff @(posedge clk or negedge rst) begin
            if (!rst)
                r_xreg[gi] <= '0;
            else if (w_we && rd == 5'(gi))
                r_xreg[gi] <= w_wb_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_reg1    <= '0;
            r_reg2    <= '0;
            r_alu_out <= '0;
        end else begin
            if (rden) begin
                r_reg1 <= w_rdata1;
                r_reg2 <= w_rdata2;
            end
            r_alu_out <= w_alu_res;
        end
    end

    assign reg1    = r_reg1;
    assign reg2    = r_reg2;
    assign alu_out = r_alu_out;
endmodule

// File: tb/tb_rv32_exec_core.sv
// Directed bench for rv32_exec_core: stimulus pushes expected values into a scoreboard
// queue; a separate monitor pops and compares them when stimulus marks outputs as ready.
module tb_rv32_exec_core;
    logic        clk;
    logic        rst;
    logic [31:0] insn;
    logic        rden;
    logic        wren;
    logic [31:0] wb_link;
    logic [4:0]  opcode;
    logic [3:0]  alu_op;
    logic        invalid;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [31:0] reg1;
    logic [31:0] reg2;
    logic [31:0] alu_out;

    rv32_exec_core dut (
        .clk(clk), .rst(rst), .insn(insn), .rden(rden), .wren(wren), .wb_link(wb_link),
        .opcode(opcode), .alu_op(alu_op), .invalid(invalid), .rd(rd), .rs1(rs1), .rs2(rs2),
        .imm(imm), .reg1(reg1), .reg2(reg2), .alu_out(alu_out)
    );

    localparam int K_ALU = 0, K_REG1 = 1, K_REG2 = 2, K_IMM = 3, K_ALUOP = 4, K_INV = 5, K_OPC = 6, K_RD = 7;

    typedef struct {
        int          kind;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t        sb_q[$];
    event        chk_ev;
    int          n_checks = 0;
    int          n_pass   = 0;
    logic        clk_run;
    exp_t        mon_e;
    logic [31:0] mon_act;

    initial begin
        clk = 1'b0;
        forever begin
            #5;
            if (clk_run) clk = ~clk;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Monitor: drains the scoreboard whenever the stimulus flags the outputs as settled.
    always @(chk_ev) begin
        while (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            case (mon_e.kind)
                K_ALU:   mon_act = alu_out;
                K_REG1:  mon_act = reg1;
                K_REG2:  mon_act = reg2;
                K_IMM:   mon_act = imm;
                K_ALUOP: mon_act = {28'b0, alu_op};
                K_INV:   mon_act = {31'b0, invalid};
                K_OPC:   mon_act = {27'b0, opcode};
                default: mon_act = {27'b0, rd};
            endcase
            n_checks++;
            if (mon_act === mon_e.exp)
                n_pass++;
            else
                $display("FAIL %s: got 0x%08h expected 0x%08h", mon_e.name, mon_act, mon_e.exp);
        end
    end

    task automatic push_exp(input int kind, input logic [31:0] exp, input string name);
        exp_t e;
        e.kind = kind;
        e.exp  = exp;
        e.name = name;
        sb_q.push_back(e);
    endtask

    // Full sequencer pass: read (E0), execute (E1), write back (E2).
    task automatic exec(input logic [31:0] ins, input logic [31:0] link, input logic [31:0] e1,
                        input logic [31:0] e2, input logic [31:0] ea, input string tag);
        @(negedge clk);
        insn = ins; wb_link = link; rden = 1'b1;
        @(negedge clk);
        rden = 1'b0;
        push_exp(K_REG1, e1, {tag, ".reg1"});
        push_exp(K_REG2, e2, {tag, ".reg2"});
        ->chk_ev;
        @(negedge clk);
        push_exp(K_ALU, ea, {tag, ".alu_out"});
        ->chk_ev;
        wren = 1'b1;
        @(negedge clk);
        wren = 1'b0;
        $display("txn %s insn=0x%08h", tag, ins);
    endtask

    task automatic read_pair(input logic [4:0] a, input logic [4:0] b, input logic [31:0] e1,
                             input logic [31:0] e2, input string tag);
        @(negedge clk);
        insn = {7'b0, b, a, 3'b000, 5'd0, 7'b0110011};
        rden = 1'b1;
        @(negedge clk);
        rden = 1'b0;
        push_exp(K_REG1, e1, {tag, ".reg1"});
        push_exp(K_REG2, e2, {tag, ".reg2"});
        ->chk_ev;
        $display("txn %s read x%0d x%0d", tag, a, b);
    endtask

    task automatic check_dec(input logic [4:0] opc, input logic [3:0] aop, input logic inv,
                             input logic [31:0] im, input string tag);
        #1;
        push_exp(K_OPC, {27'b0, opc}, {tag, ".opcode"});
        push_exp(K_ALUOP, {28'b0, aop}, {tag, ".alu_op"});
        push_exp(K_INV, {31'b0, inv}, {tag, ".invalid"});
        push_exp(K_IMM, im, {tag, ".imm"});
        ->chk_ev;
        $display("txn %s decode insn=0x%08h", tag, insn);
    endtask

    initial begin
        rst = 1'b0; insn = 32'h0000_0013; rden = 1'b0; wren = 1'b0; wb_link = '0;
        clk_run = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;

        exec(32'h0050_0093, 32'h0, 32'h0, 32'h0, 32'h5, "addi_x1");
        check_dec(5'b00100, 4'b0000, 1'b0, 32'h5, "addi_x1");
        exec(32'h0010_8133, 32'h0, 32'h5, 32'h5, 32'hA, "add_x2");
        exec(32'h4020_81B3, 32'h0, 32'h5, 32'hA, 32'hFFFF_FFFB, "sub_x3");
        check_dec(5'b01100, 4'b1000, 1'b0, 32'h0, "sub_x3");
        exec(32'h4011_D213, 32'h0, 32'hFFFF_FFFB, 32'h5, 32'hFFFF_FFFD, "srai_x4");
        check_dec(5'b00100, 4'b1101, 1'b0, 32'h401, "srai_x4");
        exec(32'h0011_B2B3, 32'h0, 32'hFFFF_FFFB, 32'h5, 32'h0, "sltu_x5");
        check_dec(5'b01100, 4'b0011, 1'b0, 32'h0, "sltu_x5");
        exec(32'h0011_A333, 32'h0, 32'hFFFF_FFFB, 32'h5, 32'h1, "slt_x6");
        exec(32'h0070_0013, 32'h0, 32'h0, 32'h0, 32'h7, "addi_x0");
        read_pair(5'd0, 5'd6, 32'h0, 32'h1, "rd_x0_x6");
        read_pair(5'd2, 5'd3, 32'hA, 32'hFFFF_FFFB, "rd_x2_x3");
        read_pair(5'd4, 5'd5, 32'hFFFF_FFFD, 32'h0, "rd_x4_x5");

        exec(32'h0080_00EF, 32'h104, 32'h0, 32'h0, 32'h0, "jal_x1");
        check_dec(5'b11011, 4'b0000, 1'b0, 32'h8, "jal_x1");
        push_exp(K_RD, 32'h1, "jal_x1.rd");
        ->chk_ev;
        read_pair(5'd1, 5'd4, 32'h104, 32'hFFFF_FFFD, "rd_x1_x4");

        @(negedge clk); insn = 32'hFFFF_FFFF;
        check_dec(5'b11111, 4'b0000, 1'b1, 32'h0, "ill_ones");
        @(negedge clk); insn = 32'h0000_0013;
        check_dec(5'b00100, 4'b0000, 1'b0, 32'h0, "nop");
        @(negedge clk); insn = 32'h4020_F1B3;
        check_dec(5'b01100, 4'b0000, 1'b1, 32'h0, "ill_and_f7");
        @(negedge clk); insn = 32'h0050_0091;
        check_dec(5'b00100, 4'b0000, 1'b1, 32'h0, "ill_lowbits");
        @(negedge clk); insn = 32'hFE00_0EE3;
        check_dec(5'b11000, 4'b0000, 1'b0, 32'hFFFF_FFFC, "beq_back");

        // Same-edge read and write of x1: the read must see the pre-write value.
        read_pair(5'd2, 5'd0, 32'hA, 32'h0, "prime_reg1");
        @(negedge clk); insn = 32'h0550_8093;
        @(negedge clk);
        push_exp(K_ALU, 32'h5F, "rw_same.alu_out");
        ->chk_ev;
        rden = 1'b1; wren = 1'b1;
        @(negedge clk);
        rden = 1'b0; wren = 1'b0;
        push_exp(K_REG1, 32'h104, "rw_same.reg1_old");
        ->chk_ev;
        $display("txn rw_same insn=0x%08h", insn);
        read_pair(5'd1, 5'd0, 32'h5F, 32'h0, "rd_x1_new");

        // Asynchronous reset with the clock stopped.
        @(negedge clk);
        clk_run = 1'b0;
        #3 rst = 1'b0;
        #2;
        push_exp(K_ALU, 32'h0, "async_rst.alu_out");
        push_exp(K_REG1, 32'h0, "async_rst.reg1");
        push_exp(K_REG2, 32'h0, "async_rst.reg2");
        ->chk_ev;
        $display("txn async_rst clock stopped");
        #5 rst = 1'b1;
        clk_run = 1'b1;
        for (int k = 0; k < 16; k++)
            read_pair(5'(2 * k), 5'(2 * k + 1), 32'h0, 32'h0, "post_rst");

        #1;
        ->chk_ev;
        #1;
        if (sb_q.size() != 0) begin
            n_checks++;
            $display("FAIL scoreboard_drain: got %0d entries expected 0", sb_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
